// File: rtl/uart_fifo_pico_pkg.sv
// Shared definitions for the picorv32 UART with TX/RX FIFOs:
// register offsets, bit positions, FSM states and the CTRL layout.
package uart_fifo_pico_pkg;

  localparam logic [31:0] OFF_DATA = 32'h0;
  localparam logic [31:0] OFF_STAT = 32'h4;
  localparam logic [31:0] OFF_CTRL = 32'h8;

  localparam int ST_RX_OVF = 5;
  localparam int ST_TX_OVF = 6;
  localparam int ST_FRAME  = 7;
  localparam int ST_PAR    = 8;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
    TX_PAR, TX_STOP1, TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
    RX_PAR, RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic        ie_tx;
    logic        ie_rx;
    logic        two_stop;
    logic        par_odd;
    logic        par_en;
    logic [11:0] cpb;
  } ctrl_t;

  typedef struct packed {
    logic par_err;
    logic frame_err;
    logic tx_ovf;
    logic rx_ovf;
    logic tx_busy;
    logic tx_full;
    logic tx_empty;
    logic rx_full;
    logic rx_nempty;
  } status_t;

  // Bit periods below 2 clocks cannot be timed, so clamp them.
  function automatic logic [11:0] eff_cpb(input logic [11:0] c);
    return (c < 12'd2) ? 12'd2 : c;
  endfunction

endpackage

// File: rtl/uart_fifo_pico_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers.
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = wptr == rptr;
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_fifo_pico.sv
// Memory-mapped UART for the picorv32 native bus with TX/RX FIFOs,
// programmable framing, sticky error flags and a level interrupt.
module uart_fifo_pico
  import uart_fifo_pico_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [11:0] DEFAULT_CPB = 12'd104
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  input  logic        rx_uart,
  output logic        tx_uart,
  output logic        irq
);

  localparam ctrl_t CTRL_RST = '{1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, DEFAULT_CPB};

  ctrl_t       ctrl;
  status_t     status;
  logic [31:0] off;
  logic        is_data, is_stat, is_ctrl;
  logic        sel, wr;
  logic [31:0] rd_val;

  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_rd;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_rd;

  logic        rx_ovf, tx_ovf, frame_err, par_err;
  logic        rx_ovf_set, tx_ovf_set, frame_set, par_set;
  logic [3:0]  clr;

  tx_state_t   tx_state;
  logic [11:0] tx_cpb, tx_cnt;
  logic [7:0]  tx_sh;
  logic [2:0]  tx_idx;
  logic        tx_par, tx_pe, tx_two, tx_tick;

  rx_state_t   rx_state;
  logic [1:0]  rx_sync;
  logic        rx_s;
  logic [11:0] rx_cpb, rx_cnt;
  logic [7:0]  rx_sh;
  logic [2:0]  rx_idx;
  logic        rx_pe, rx_odd, rx_wait;
  logic        rx_tick, rx_half, rx_done;

  assign off     = mem_addr - BASE_ADDR;
  assign is_data = off == OFF_DATA;
  assign is_stat = off == OFF_STAT;
  assign is_ctrl = off == OFF_CTRL;
  assign sel     = mem_valid && !mem_ready &&
                   (is_data || is_stat || is_ctrl);
  assign wr      = |mem_wstrb;

  assign tx_push    = sel && wr && is_data && !tx_full;
  assign tx_ovf_set = sel && wr && is_data && tx_full;
  assign rx_pop     = sel && !wr && is_data && !rx_empty;
  assign clr        = (sel && wr && is_stat) ?
                      mem_wdata[ST_PAR:ST_RX_OVF] : 4'b0;

  assign status = '{par_err, frame_err, tx_ovf, rx_ovf,
                    tx_state != TX_IDLE, tx_full, tx_empty,
                    rx_full, !rx_empty};

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      is_data: rd_val = rx_empty ? 32'h0 : {24'h0, rx_rd};
      is_stat: rd_val = {23'h0, status};
      is_ctrl: rd_val = {14'h0, ctrl.ie_tx, ctrl.ie_rx, 1'b0,
                         ctrl.two_stop, ctrl.par_odd,
                         ctrl.par_en, ctrl.cpb};
      default: rd_val = '0;
    endcase
  end

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rstn(rstn),
    .push(tx_push), .pop(tx_pop),
    .wdata(mem_wdata[7:0]), .rdata(tx_rd),
    .full(tx_full), .empty(tx_empty)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rstn(rstn),
    .push(rx_push && !rx_full), .pop(rx_pop),
    .wdata(rx_sh), .rdata(rx_rd),
    .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      ctrl      <= CTRL_RST;
      rx_ovf    <= 1'b0;
      tx_ovf    <= 1'b0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      mem_ready <= sel;
      mem_rdata <= (sel && !wr) ? rd_val : 32'h0;
      if (sel && wr && is_ctrl) begin
        if (mem_wstrb[0]) ctrl.cpb[7:0] <= mem_wdata[7:0];
        if (mem_wstrb[1]) begin
          ctrl.cpb[11:8] <= mem_wdata[11:8];
          ctrl.par_en    <= mem_wdata[12];
          ctrl.par_odd   <= mem_wdata[13];
          ctrl.two_stop  <= mem_wdata[14];
        end
        if (mem_wstrb[2]) begin
          ctrl.ie_rx <= mem_wdata[16];
          ctrl.ie_tx <= mem_wdata[17];
        end
      end
      // A new event wins over a clear arriving in the same cycle.
      rx_ovf    <= (rx_ovf    && !clr[0]) || rx_ovf_set;
      tx_ovf    <= (tx_ovf    && !clr[1]) || tx_ovf_set;
      frame_err <= (frame_err && !clr[2]) || frame_set;
      par_err   <= (par_err   && !clr[3]) || par_set;
      irq <= (ctrl.ie_rx && !rx_empty) ||
             (ctrl.ie_tx && tx_empty && tx_state == TX_IDLE);
    end
  end

  assign tx_tick = tx_cnt == tx_cpb - 12'd1;
  assign tx_pop  = tx_state == TX_IDLE && !tx_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= TX_IDLE;
      tx_uart  <= 1'b1;
      tx_cpb   <= 12'd2;
      tx_cnt   <= '0;
      tx_sh    <= '0;
      tx_idx   <= '0;
      tx_par   <= 1'b0;
      tx_pe    <= 1'b0;
      tx_two   <= 1'b0;
    end else if (tx_state == TX_IDLE) begin
      tx_uart <= 1'b1;
      if (!tx_empty) begin
        tx_state <= TX_START;
        tx_uart  <= 1'b0;
        tx_sh    <= tx_rd;
        tx_par   <= (^tx_rd) ^ ctrl.par_odd;
        tx_pe    <= ctrl.par_en;
        tx_two   <= ctrl.two_stop;
        tx_cpb   <= eff_cpb(ctrl.cpb);
        tx_cnt   <= '0;
        tx_idx   <= '0;
      end
    end else if (!tx_tick) begin
      tx_cnt <= tx_cnt + 12'd1;
    end else begin
      tx_cnt <= '0;
      case (tx_state)
        TX_START: begin
          tx_state <= TX_DATA;
          tx_uart  <= tx_sh[0];
        end
        TX_DATA: begin
          if (tx_idx == 3'd7) begin
            tx_state <= tx_pe ? TX_PAR : TX_STOP1;
            tx_uart  <= tx_pe ? tx_par : 1'b1;
          end else begin
            tx_idx  <= tx_idx + 3'd1;
            tx_sh   <= tx_sh >> 1;
            tx_uart <= tx_sh[1];
          end
        end
        TX_PAR: begin
          tx_state <= TX_STOP1;
          tx_uart  <= 1'b1;
        end
        TX_STOP1: tx_state <= tx_two ? TX_STOP2 : TX_IDLE;
        default:  tx_state <= TX_IDLE;
      endcase
    end
  end

  assign rx_s       = rx_sync[1];
  assign rx_tick    = rx_cnt == rx_cpb - 12'd1;
  assign rx_half    = rx_cnt == ((rx_cpb - 12'd1) >> 1);
  assign rx_done    = rx_state == RX_STOP && !rx_wait && rx_tick;
  assign rx_push    = rx_done;
  assign rx_ovf_set = rx_done && rx_full;
  assign frame_set  = rx_done && !rx_s;
  assign par_set    = rx_state == RX_PAR && rx_tick &&
                      (rx_s != ((^rx_sh) ^ rx_odd));

  // A low stop bit (break) holds RX until the line idles again.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_sync  <= 2'b11;
      rx_state <= RX_IDLE;
      rx_cpb   <= 12'd2;
      rx_cnt   <= '0;
      rx_sh    <= '0;
      rx_idx   <= '0;
      rx_pe    <= 1'b0;
      rx_odd   <= 1'b0;
      rx_wait  <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx_uart};
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_cpb   <= eff_cpb(ctrl.cpb);
            rx_pe    <= ctrl.par_en;
            rx_odd   <= ctrl.par_odd;
          end
        end
        RX_START: begin
          if (!rx_half) rx_cnt <= rx_cnt + 12'd1;
          else begin
            rx_cnt   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (!rx_tick) rx_cnt <= rx_cnt + 12'd1;
          else begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_idx <= rx_idx + 3'd1;
            if (rx_idx == 3'd7)
              rx_state <= rx_pe ? RX_PAR : RX_STOP;
          end
        end
        RX_PAR: begin
          if (!rx_tick) rx_cnt <= rx_cnt + 12'd1;
          else begin
            rx_cnt   <= '0;
            rx_state <= RX_STOP;
          end
        end
        default: begin
          if (rx_wait) begin
            if (rx_s) begin
              rx_wait  <= 1'b0;
              rx_state <= RX_IDLE;
            end
          end else if (!rx_tick) begin
            rx_cnt <= rx_cnt + 12'd1;
          end else begin
            rx_cnt <= '0;
            if (rx_s) rx_state <= RX_IDLE;
            else      rx_wait  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_pico.sv
// Scenario bench for uart_fifo_pico: TX framing, loopback with parity,
// RX errors, RX/TX overflow, interrupts and mid-frame reset.
module tb_uart_fifo_pico;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        rx_uart;
  logic        tx_uart;
  logic        irq;

  logic        loop = 1'b0;
  logic        rx_drv = 1'b1;
  int          cur_cpb = 4;
  bit          cur_pe = 1'b0;
  bit          cur_odd = 1'b0;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  sb_byte[$];
  logic        sb_bit[$];

  assign rx_uart = loop ? tx_uart : rx_drv;

  always #5 clk = ~clk;

  uart_fifo_pico #(
    .BASE_ADDR(BASE), .FIFO_DEPTH(16), .DEFAULT_CPB(12'd104)
  ) dut (
    .clk(clk), .rstn(rstn),
    .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rx_uart(rx_uart), .tx_uart(tx_uart), .irq(irq)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r,
                          output int lat);
    @(negedge clk);
    if (mem_ready) @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    lat = 0;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (mem_ready) begin
        r = mem_rdata;
        break;
      end
    end
    if (!mem_ready) begin
      tests++;
      fails++;
      $display("FAIL bus_timeout addr=%h", a);
    end
    mem_valid = 1'b0;
    mem_wstrb = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int lat;
    bus_xfer(a, d, 4'hF, r, lat);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    int lat;
    bus_xfer(a, 32'h0, 4'h0, r, lat);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit bad_par,
                         input bit bad_stop);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (cur_cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (cur_cpb) @(negedge clk);
    end
    if (cur_pe) begin
      rx_drv = (^b) ^ cur_odd ^ bad_par;
      repeat (cur_cpb) @(negedge clk);
    end
    rx_drv = !bad_stop;
    repeat (cur_cpb) @(negedge clk);
    rx_drv = 1'b1;
    repeat (cur_cpb) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    tick(3);
    tests++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 ||
        tx_uart !== 1'b1 || irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%b rdata=%h tx=%b irq=%b",
               mem_ready, mem_rdata, tx_uart, irq);
    end
    @(negedge clk);
    rstn = 1'b1;
    rd(A_STAT, r);
    tests++;
    if (r !== 32'h4) begin
      fails++;
      $display("FAIL reset_status got %h want 00000004", r);
    end
    rd(A_CTRL, r);
    tests++;
    if (r !== 32'd104) begin
      fails++;
      $display("FAIL reset_ctrl got %h want %h", r, 32'd104);
    end
  endtask

  task automatic test_tx_frame;
    logic [31:0] r;
    logic [7:0]  b;
    logic        e;
    int          lat;
    bit          seen;
    wr(A_CTRL, 32'd4);
    b = 8'hA5;
    sb_bit.push_back(1'b0);
    for (int i = 0; i < 8; i++) sb_bit.push_back(b[i]);
    sb_bit.push_back(1'b1);
    bus_xfer(A_DATA, {24'h0, b}, 4'hF, r, lat);
    tests++;
    if (lat !== 1) begin
      fails++;
      $display("FAIL tx_ack_latency got %0d want 1", lat);
    end
    tick(1);
    tests++;
    if (mem_ready !== 1'b0) begin
      fails++;
      $display("FAIL tx_ack_width got rdy=%b want 0", mem_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (tx_uart === 1'b0) seen = 1'b1;
      else tick(1);
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL tx_start_timeout got tx=%b want 0", tx_uart);
    end
    tick(2);
    for (int i = 0; i < 10; i++) begin
      e = sb_bit.pop_front();
      tests++;
      if (tx_uart !== e) begin
        fails++;
        $display("FAIL tx_bit%0d got %b want %b", i, tx_uart, e);
      end
      tick(4);
    end
    tick(8);
  endtask

  task automatic test_loopback;
    logic [31:0] r;
    logic [7:0]  e;
    logic [7:0]  pat[3];
    pat[0] = 8'h00;
    pat[1] = 8'hFF;
    pat[2] = 8'h3C;
    loop = 1'b1;
    wr(A_CTRL, 32'd8 | (32'd1 << 12) | (32'd1 << 13));
    for (int i = 0; i < 3; i++) begin
      sb_byte.push_back(pat[i]);
      wr(A_DATA, {24'h0, pat[i]});
    end
    tick(450);
    rd(A_STAT, r);
    tests++;
    if ((r & 32'h181) !== 32'h001) begin
      fails++;
      $display("FAIL loop_status got %h want err=0 rx_nempty=1", r);
    end
    for (int i = 0; i < 3; i++) begin
      rd(A_DATA, r);
      e = sb_byte.pop_front();
      tests++;
      if (r !== {24'h0, e}) begin
        fails++;
        $display("FAIL loop_byte%0d got %h want %h", i, r, e);
      end
    end
    loop = 1'b0;
  endtask

  task automatic test_irq;
    logic [31:0] r;
    cur_cpb = 8;
    cur_pe  = 1'b0;
    wr(A_CTRL, 32'd8 | (32'd1 << 16));
    tick(2);
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_idle got %b want 0", irq);
    end
    send_rx(8'h33, 1'b0, 1'b0);
    tick(3);
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL irq_rx got %b want 1", irq);
    end
    rd(A_DATA, r);
    tests++;
    if (r !== 32'h33) begin
      fails++;
      $display("FAIL irq_data got %h want 00000033", r);
    end
    tick(2);
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_clear got %b want 0", irq);
    end
    wr(A_CTRL, 32'd8 | (32'd1 << 17));
    tick(3);
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL irq_tx got %b want 1", irq);
    end
    wr(A_CTRL, 32'd8);
  endtask

  task automatic test_rx_errors;
    logic [31:0] r;
    cur_cpb = 8;
    cur_pe  = 1'b1;
    cur_odd = 1'b0;
    wr(A_CTRL, 32'd8 | (32'd1 << 12));
    send_rx(8'h5A, 1'b1, 1'b1);
    tick(2);
    rd(A_STAT, r);
    tests++;
    if ((r & 32'h181) !== 32'h181) begin
      fails++;
      $display("FAIL rxerr_flags got %h want bits 8,7,0 set", r);
    end
    rd(A_DATA, r);
    tests++;
    if (r !== 32'h5A) begin
      fails++;
      $display("FAIL rxerr_byte got %h want 0000005a", r);
    end
    rd(A_DATA, r);
    tests++;
    if (r !== 32'h0) begin
      fails++;
      $display("FAIL rx_empty_read got %h want 00000000", r);
    end
    wr(A_STAT, 32'h180);
    rd(A_STAT, r);
    tests++;
    if ((r & 32'h1A3) !== 32'h0) begin
      fails++;
      $display("FAIL rxerr_w1c got %h want bits 8,7,5,1,0 clear", r);
    end
  endtask

  task automatic test_rx_overflow;
    logic [31:0] r;
    logic [7:0]  b;
    logic [7:0]  e;
    cur_cpb = 4;
    cur_pe  = 1'b0;
    wr(A_CTRL, 32'd4);
    for (int i = 0; i < 17; i++) begin
      b = 8'(i * 13 + 7);
      if (i < 16) sb_byte.push_back(b);
      send_rx(b, 1'b0, 1'b0);
    end
    rd(A_STAT, r);
    tests++;
    if ((r & 32'h23) !== 32'h23) begin
      fails++;
      $display("FAIL rxovf_status got %h want bits 5,1,0 set", r);
    end
    for (int i = 0; i < 16; i++) begin
      rd(A_DATA, r);
      e = sb_byte.pop_front();
      tests++;
      if (r !== {24'h0, e}) begin
        fails++;
        $display("FAIL rxovf_byte%0d got %h want %h", i, r, e);
      end
    end
    wr(A_STAT, 32'h20);
    rd(A_STAT, r);
    tests++;
    if ((r & 32'h23) !== 32'h0) begin
      fails++;
      $display("FAIL rxovf_clear got %h want bits 5,1,0 clear", r);
    end
  endtask

  task automatic test_tx_overflow;
    logic [31:0] r;
    wr(A_CTRL, 32'd4095);
    for (int i = 0; i < 18; i++) wr(A_DATA, 32'(i));
    rd(A_STAT, r);
    tests++;
    if ((r & 32'h5C) !== 32'h58) begin
      fails++;
      $display("FAIL txovf_status got %h want full,busy,ovf set", r);
    end
    wr(A_STAT, 32'h40);
    rd(A_STAT, r);
    tests++;
    if ((r & 32'h48) !== 32'h08) begin
      fails++;
      $display("FAIL txovf_clear got %h want ovf=0 full=1", r);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] r;
    tests++;
    if (tx_uart !== 1'b0) begin
      fails++;
      $display("FAIL midframe_pre got tx=%b want 0", tx_uart);
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    tests++;
    if (tx_uart !== 1'b1) begin
      fails++;
      $display("FAIL midframe_abort got tx=%b want 1", tx_uart);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rd(A_STAT, r);
    tests++;
    if (r !== 32'h4) begin
      fails++;
      $display("FAIL midframe_status got %h want 00000004", r);
    end
    rd(A_CTRL, r);
    tests++;
    if (r !== 32'd104) begin
      fails++;
      $display("FAIL midframe_ctrl got %h want %h", r, 32'd104);
    end
  endtask

  initial begin
    test_reset;
    test_tx_frame;
    test_loopback;
    test_irq;
    test_rx_errors;
    test_rx_overflow;
    test_tx_overflow;
    test_reset_mid_frame;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
